mem_subword_unit: RTL and testbench
===================================

Name: mem_subword_unit

Overview:
- Data-memory access unit between the datapath and a word-wide, byte-unaddressable data memory with synchronous read.
- Provides the data-side counterpart of immediate widening:
  - narrows 32-bit register data into byte/half stores, done by read-modify-write;
  - extracts and zero- or sign-extends sub-word load data back to 32 bits.
- Sits between the MEM-stage control and the DM macro, and stalls the datapath via busy.

Parameters:
- ADDR_W, 32, byte-address width; mem_addr keeps the same width with bits [1:0] forced to 0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  3  operation: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- addr  input  ADDR_W  byte address; captured with start.
- wdata  input  32  store data; captured with start; only the low byte/half is used for SB/SH.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- rdata  output  32  extended load result; registered, held until the next load completes.
- misalign  output  1  valid with done; 1 = request rejected for alignment.
- mem_addr  output  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}.
- mem_re  output  1  memory read enable.
- mem_we  output  1  memory write enable; full-word write.
- mem_wdata  output  32  word to write.
- mem_rdata  input  32  read data; valid in the cycle after mem_re is high.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - busy, done, misalign, mem_re and mem_we are 0.
  - rdata, mem_wdata and all captured registers are 0.
  - Reset mid-operation aborts immediately; no write is issued afterwards.
- Byte order is little-endian.
  - Byte lane b = addr[1:0] occupies bits [8b+7:8b].
  - Half lane = addr[1]: 0 selects [15:0], 1 selects [31:16].
- FSM states: IDLE, RD, CAP, WR, DONE.
- Transitions out of IDLE on start=1:
  - Misaligned request (LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]=1) -> DONE with misalign=1.
  - SW -> WR.
  - All other ops -> RD.
  - op, addr and wdata are latched on the same edge.
- RD: mem_re=1 for exactly one cycle -> CAP.
- CAP: mem_rdata is valid and is registered.
  - Loads:
    - rdata <= extended value (LW: whole word; LB/LH: sign-extended; LBU/LHU: zero-extended).
    - Next state DONE.
  - SB/SH:
    - merge register <= mem_rdata with only the selected lane replaced by wdata[7:0] or wdata[15:0].
    - Next state WR.
- WR:
  - mem_we=1 for exactly one cycle.
  - mem_wdata = merged word for SB/SH, or the latched wdata for SW.
  - Next state DONE.
- DONE: done=1 for one cycle, misalign valid -> IDLE.
  - misalign returns to 0 on the next accepted start.
- mem_addr is driven from the latched address in all non-IDLE states; 0 in IDLE.
- Latency from the start edge to done high:
  - LW/LB/LH/LBU/LHU: 3 cycles.
  - SB/SH: 4 cycles.
  - SW: 2 cycles.
  - misaligned request: 1 cycle.
- start while busy=1 is ignored (no queueing). The requester must hold off until done.
- start in the same cycle as done is also ignored; the FSM is not in IDLE until the next cycle.
- Misaligned requests issue no mem_re and no mem_we, and leave rdata unchanged.
- mem_re and mem_we are never high in the same cycle.
- No read or write is ever issued outside the RD/WR states.

Test Plan:
- Reset mid-op: reset low in the CAP state of an SB.
  - All outputs 0 immediately.
  - mem_we never asserted.
  - Next SW after release is accepted normally.
- LB sign extension: memory word 0x12F4_80AB, LB addr=0x...1.
  - rdata=0xFFFF_FF80.
  - done exactly 3 cycles after start.
  - Exactly one mem_re pulse.
- LHU/LH: same word, LHU addr=0x...2 -> rdata=0x0000_12F4; LH addr=0x...0 -> rdata=0xFFFF_80AB.
- SB read-modify-write: word 0x1122_3344, SB addr=0x...2, wdata=0xDEAD_BEEF.
  - One mem_wdata write of 0x11EF_3344.
  - done 4 cycles after start.
  - A subsequent LW returns 0x11EF_3344.
- SW and SH: SW wdata=0xCAFE_F00D -> one-cycle write of 0xCAFE_F00D, no mem_re, done after 2 cycles; SH addr=0x...2, wdata=0x0000_5A5A over 0x1122_3344 -> write of 0x5A5A_3344.
- Misalignment and busy: LW addr=0x...3 -> done+misalign=1 after 1 cycle, no mem_re/mem_we, rdata unchanged; start pulses while busy are ignored (exactly one memory transaction per accepted start).

Source files
------------

// File: rtl/mem_subword_unit.sv
// Data-memory access unit: sub-word loads with zero/sign extension and
// byte/half stores by read-modify-write over a word-wide synchronous-read memory.
module mem_subword_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    logic [2:0]        state;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       merge_q;
    logic              bad_align;
    logic [4:0]        lane_shift;
    logic [31:0]       shifted;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    always_comb begin
        bad_align = 1'b0;
        case (op)
            OP_LW, OP_SW:         bad_align = (addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: bad_align = addr[0];
            default:              bad_align = 1'b0;
        endcase
    end

    // merge_q holds the store data from acceptance until CAP overwrites it with the merged word
    always_comb begin
        lane_shift = {addr_q[1:0], 3'b000};
        shifted    = mem_rdata >> lane_shift;
        byte_sel   = shifted[7:0];
        half_sel   = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q)
            OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_val = {16'h0000, half_sel};
            OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_val = {24'h000000, byte_sel};
            default: load_val = mem_rdata;
        endcase
        if (op_q == OP_SH) begin
            merged = addr_q[1] ? {merge_q[15:0], mem_rdata[15:0]}
                               : {mem_rdata[31:16], merge_q[15:0]};
        end else begin
            merged = (mem_rdata & ~(32'h0000_00FF << lane_shift))
                   | ({24'h000000, merge_q[7:0]} << lane_shift);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            op_q     <= '0;
            addr_q   <= '0;
            merge_q  <= '0;
            rdata    <= '0;
            misalign <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        addr_q   <= addr;
                        merge_q  <= wdata;
                        misalign <= bad_align;
                        if (bad_align)        state <= S_DONE;
                        else if (op == OP_SW) state <= S_WR;
                        else                  state <= S_RD;
                    end
                end
                S_RD: state <= S_CAP;
                S_CAP: begin
                    if (op_q == OP_SB || op_q == OP_SH) begin
                        merge_q <= merged;
                        state   <= S_WR;
                    end else begin
                        rdata <= load_val;
                        state <= S_DONE;
                    end
                end
                S_WR:    state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign mem_re    = (state == S_RD);
    assign mem_we    = (state == S_WR);
    assign mem_wdata = merge_q;
    assign mem_addr  = (state == S_IDLE) ? '0 : {addr_q[ADDR_W-1:2], 2'b00};

endmodule

// File: tb/tb_mem_subword_unit.sv
// Self-checking bench for mem_subword_unit: byte-level reference memory,
// directed spec vectors, busy/reset corner cases and randomized operations.
module tb_mem_subword_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, done, misalign, mem_re, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    mem_subword_unit #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .misalign(misalign), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Word-wide synchronous-read memory with a backdoor preload port
    logic [31:0] mem [16];
    logic        bd_we = 1'b0;
    logic [3:0]  bd_idx = '0;
    logic [31:0] bd_val = '0;
    int re_cnt = 0, we_cnt = 0, both_cnt = 0;
    logic [31:0] last_w = '0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_val;
        if (mem_re) mem_rdata <= mem[mem_addr[5:2]];
        if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
        if (mem_re) re_cnt <= re_cnt + 1;
        if (mem_we) begin
            we_cnt <= we_cnt + 1;
            last_w <= mem_wdata;
        end
        if (mem_re && mem_we) both_cnt <= both_cnt + 1;
    end

    // Reference model: memory as an array of bytes
    logic [7:0]  ref_b [64];
    logic [31:0] exp_rdata = '0;

    function automatic logic [31:0] ref_word(input int a);
        int b;
        b = a & 60;
        return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
    endfunction

    function automatic logic is_bad(input logic [2:0] o, input int a);
        if (o == 3'd0 || o == 3'd5) return (a % 4) != 0;
        if (o == 3'd1 || o == 3'd2 || o == 3'd6) return (a % 2) != 0;
        return 1'b0;
    endfunction

    task automatic preload(input int idx, input logic [31:0] v);
        bd_idx = idx[3:0];
        bd_val = v;
        bd_we  = 1'b1;
        @(posedge clk); #1;
        bd_we = 1'b0;
        for (int k = 0; k < 4; k++) ref_b[idx*4+k] = v[8*k +: 8];
    endtask

    task automatic run_op(input logic [2:0] o, input int a, input logic [31:0] w);
        int n, re0, we0, lat, exp_re, exp_we;
        logic bad;
        logic [7:0]  bv;
        logic [15:0] hv;
        n = 0;
        @(negedge clk);
        while (busy && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_wait: busy=%b required 0", busy);
        end
        bad = is_bad(o, a);
        if (bad) begin lat = 1; exp_re = 0; exp_we = 0; end
        else if (o == 3'd5) begin lat = 2; exp_re = 0; exp_we = 1; end
        else if (o >= 3'd6) begin lat = 4; exp_re = 1; exp_we = 1; end
        else begin lat = 3; exp_re = 1; exp_we = 0; end
        re0 = re_cnt; we0 = we_cnt;
        start = 1'b1; op = o; addr = a; wdata = w;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 12) begin @(posedge clk); #1; n++; end
        checks++;
        if (done !== 1'b1 || n != lat) begin
            errors++;
            $display("FAIL latency op=%0d addr=%h: got %0d cycles (done=%b) required %0d", o, a, n, done, lat);
        end
        checks++;
        if (misalign !== bad) begin
            errors++;
            $display("FAIL misalign op=%0d addr=%h: got %b required %b", o, a, misalign, bad);
        end
        if (!bad) begin
            bv = ref_b[a & 63];
            hv = {ref_b[(a+1) & 63], ref_b[a & 63]};
            case (o)
                3'd0: exp_rdata = ref_word(a);
                3'd1: exp_rdata = 32'($signed(hv));
                3'd2: exp_rdata = 32'(hv);
                3'd3: exp_rdata = 32'($signed(bv));
                3'd4: exp_rdata = 32'(bv);
                3'd5: for (int k = 0; k < 4; k++) ref_b[(a & 60) + k] = w[8*k +: 8];
                3'd6: begin ref_b[a] = w[7:0]; ref_b[a+1] = w[15:8]; end
                default: ref_b[a] = w[7:0];
            endcase
        end
        checks++;
        if (rdata !== exp_rdata) begin
            errors++;
            $display("FAIL rdata op=%0d addr=%h: got %h required %h", o, a, rdata, exp_rdata);
        end
        checks++;
        if (re_cnt - re0 != exp_re || we_cnt - we0 != exp_we) begin
            errors++;
            $display("FAIL mem_pulses op=%0d addr=%h: got re=%0d we=%0d required re=%0d we=%0d",
                     o, a, re_cnt - re0, we_cnt - we0, exp_re, exp_we);
        end
        if (exp_we == 1) begin
            checks++;
            if (last_w !== ref_word(a)) begin
                errors++;
                $display("FAIL write_word op=%0d addr=%h: got %h required %h", o, a, last_w, ref_word(a));
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; op = '0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, misalign, mem_re, mem_we} !== 5'b0 || rdata !== '0 ||
            mem_wdata !== '0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL reset_state: got flags=%b rdata=%h wd=%h ma=%h required all zero",
                     {busy, done, misalign, mem_re, mem_we}, rdata, mem_wdata, mem_addr);
        end
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 16; i++) preload(i, $urandom);
        exp_rdata = '0;
    endtask

    task automatic test_loads;
        preload(4, 32'h12F4_80AB);
        run_op(3'd3, 32'h11, 32'h0);
        checks++;
        if (rdata !== 32'hFFFF_FF80) begin
            errors++; $display("FAIL lb_sext: got %h required %h", rdata, 32'hFFFF_FF80);
        end
        run_op(3'd2, 32'h12, 32'h0);
        checks++;
        if (rdata !== 32'h0000_12F4) begin
            errors++; $display("FAIL lhu_zext: got %h required %h", rdata, 32'h0000_12F4);
        end
        run_op(3'd1, 32'h10, 32'h0);
        checks++;
        if (rdata !== 32'hFFFF_80AB) begin
            errors++; $display("FAIL lh_sext: got %h required %h", rdata, 32'hFFFF_80AB);
        end
        run_op(3'd4, 32'h13, 32'h0);
        checks++;
        if (rdata !== 32'h0000_0012) begin
            errors++; $display("FAIL lbu_zext: got %h required %h", rdata, 32'h0000_0012);
        end
    endtask

    task automatic test_stores;
        preload(8, 32'h1122_3344);
        run_op(3'd7, 32'h22, 32'hDEAD_BEEF);
        checks++;
        if (last_w !== 32'h11EF_3344) begin
            errors++; $display("FAIL sb_merge: got %h required %h", last_w, 32'h11EF_3344);
        end
        run_op(3'd0, 32'h20, 32'h0);
        checks++;
        if (rdata !== 32'h11EF_3344) begin
            errors++; $display("FAIL sb_readback: got %h required %h", rdata, 32'h11EF_3344);
        end
        run_op(3'd5, 32'h30, 32'hCAFE_F00D);
        checks++;
        if (last_w !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL sw_word: got %h required %h", last_w, 32'hCAFE_F00D);
        end
        preload(9, 32'h1122_3344);
        run_op(3'd6, 32'h26, 32'h0000_5A5A);
        checks++;
        if (last_w !== 32'h5A5A_3344) begin
            errors++; $display("FAIL sh_merge: got %h required %h", last_w, 32'h5A5A_3344);
        end
    endtask

    task automatic test_misalign;
        run_op(3'd0, 32'h13, 32'h0);
        run_op(3'd1, 32'h11, 32'h0);
        run_op(3'd5, 32'h32, 32'h1234_5678);
        run_op(3'd6, 32'h23, 32'h0000_ABCD);
        run_op(3'd2, 32'h15, 32'h0);
        run_op(3'd3, 32'h15, 32'h0);
    endtask

    task automatic test_busy_ignored;
        int re0, we0, n;
        @(negedge clk);
        while (busy) @(negedge clk);
        re0 = re_cnt; we0 = we_cnt;
        start = 1'b1; op = 3'd0; addr = 32'h14; wdata = '0;
        @(posedge clk); #1;
        op = 3'd5; wdata = $urandom; addr = 32'h18;
        n = 1;
        while (done !== 1'b1 && n < 12) begin @(posedge clk); #1; n++; end
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL busy_latency: got %0d required 3", n);
        end
        exp_rdata = ref_word(32'h14);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || re_cnt - re0 != 1 || we_cnt - we0 != 0) begin
            errors++;
            $display("FAIL busy_ignore: got busy=%b re=%0d we=%0d required busy=0 re=1 we=0",
                     busy, re_cnt - re0, we_cnt - we0);
        end
        checks++;
        if (rdata !== exp_rdata) begin
            errors++; $display("FAIL busy_rdata: got %h required %h", rdata, exp_rdata);
        end
    endtask

    task automatic test_reset_mid_op;
        int we0;
        @(negedge clk);
        while (busy) @(negedge clk);
        start = 1'b1; op = 3'd7; addr = 32'h25; wdata = 32'h0000_00C3;
        @(posedge clk); #1;
        start = 1'b0;
        we0 = we_cnt;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        exp_rdata = '0;
        checks++;
        if ({busy, done, misalign, mem_re, mem_we} !== 5'b0 || rdata !== '0 ||
            mem_wdata !== '0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL reset_mid_op: got flags=%b rdata=%h wd=%h ma=%h required all zero",
                     {busy, done, misalign, mem_re, mem_we}, rdata, mem_wdata, mem_addr);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (we_cnt != we0) begin
            errors++; $display("FAIL reset_no_write: got %0d writes required 0", we_cnt - we0);
        end
        run_op(3'd0, 32'h24, 32'h0);
        run_op(3'd5, 32'h24, 32'h7E57_0001);
        run_op(3'd0, 32'h24, 32'h0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++)
            run_op(3'($urandom_range(0, 7)), int'($urandom_range(0, 63)), $urandom);
        checks++;
        if (both_cnt != 0) begin
            errors++; $display("FAIL re_we_overlap: got %0d cycles required 0", both_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_loads;
        test_stores;
        test_misalign;
        test_busy_ignored;
        test_reset_mid_op;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
